// File: rtl/req_sched.sv
// req_sched: round-robin scheduler granting a shared register-update
// resource to one of NREQ requesters at a time.
// A two-state FSM (IDLE/ACTIVE) issues a registered one-hot grant one cycle
// after a request is seen in IDLE. The grant is held until the owner signals
// DONE or drops its request. Every release is followed by one dead IDLE cycle.
// Optional feature macro: REQ_SCHED_TIMEOUT_EN adds an 8-bit hold counter.
// The counter forces a release after MAX_HOLD ACTIVE cycles and pulses TIMEOUT
// for that release. When the macro is undefined, TIMEOUT is tied low.
module req_sched #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic            DONE,
    output logic [NREQ-1:0] GNT,
    output logic [2:0]      GNT_ID,
    output logic            BUSY,
    output logic            TIMEOUT
);

    // Reject illegal configurations at elaboration time
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("req_sched: NREQ must be in 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("req_sched: MAX_HOLD must be in 1..255");
    end

    localparam logic [3:0] NREQ_W  = 4'(NREQ);
    localparam logic [2:0] LAST_ID = 3'(NREQ - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [2:0]      id_q, id_d;
    logic [2:0]      ptr_q, ptr_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] scan;
    logic [2:0]      offset;
    logic            found;
    logic [3:0]      sum;
    logic [2:0]      winner;
    logic [NREQ-1:0] winner_onehot;
    logic            owner_req;
    logic            release_now;

`ifdef REQ_SCHED_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [7:0] hold_q, hold_d;
    logic [7:0] hold_inc;
    logic       expire;
    logic       timeout_q, timeout_d;
`endif

    // Round-robin search: rotate the requests so that PTR lands at bit 0,
    // take the lowest set bit, then map the offset back to an absolute index
    always_comb begin
        scan   = NREQ'({REQ, REQ} >> ptr_q);
        found  = 1'b0;
        offset = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && scan[0]) begin
                found  = 1'b1;
                offset = 3'(i);
            end
            scan = scan >> 1;
        end
        sum = {1'b0, ptr_q} + {1'b0, offset};
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        winner        = sum[2:0];
        winner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << winner;
    end

    // The owner keeps its grant only while its own request bit stays high
    assign owner_req = |(REQ & gnt_q);

`ifdef REQ_SCHED_TIMEOUT_EN
    assign hold_inc = hold_q + 8'd1;
    assign expire   = (hold_inc == HOLD_LIMIT);
`endif

    // Next-state and next-output logic; every registered output is decided here
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        id_d        = id_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        release_now = 1'b0;
`ifdef REQ_SCHED_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                id_d   = 3'd0;
                busy_d = 1'b0;
                if (found) begin
                    state_d = ACTIVE;
                    gnt_d   = winner_onehot;
                    id_d    = winner;
                    busy_d  = 1'b1;
`ifdef REQ_SCHED_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            ACTIVE: begin
                if (DONE || !owner_req) begin
                    release_now = 1'b1;
`ifdef REQ_SCHED_TIMEOUT_EN
                end else if (expire) begin
                    release_now = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    hold_d = hold_inc;
`endif
                end
                if (release_now) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = 3'd0;
                    busy_d  = 1'b0;
                    ptr_d   = (id_q == LAST_ID) ? 3'd0 : id_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= 3'd0;
            ptr_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef REQ_SCHED_TIMEOUT_EN
    // Hold counter and timeout pulse register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT    = gnt_q;
    assign GNT_ID = id_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_req_sched.sv
// tb_req_sched: self-checking bench for req_sched.
// A queue-free behavioural model (owner index, round-robin pointer, hold count)
// predicts the outputs every cycle. Directed scenarios pin the model with
// literal values. A randomized phase follows the directed scenarios.
// Honours REQ_SCHED_TIMEOUT_EN in the same way as the design.
module tb_req_sched;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 3;

    logic            CLK = 1'b0;
    logic            RST;
    logic            DONE;
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] GNT;
    logic [2:0]      GNT_ID;
    logic            BUSY;
    logic            TIMEOUT;

    int checks   = 0;
    int failures = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tmo   = 1'b0;

    int seq029 [9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    int held      = 0;
    int tmo_seen  = 0;

    req_sched #(
        .NREQ    (NREQ),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .DONE   (DONE),
        .GNT    (GNT),
        .GNT_ID (GNT_ID),
        .BUSY   (BUSY),
        .TIMEOUT(TIMEOUT)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_tmo   = 1'b0;
    endfunction

    // One clock of scheduler behaviour written from the rules themselves
    function automatic void model_step(input logic [NREQ-1:0] req, input logic done);
        int  r;
        bit  rel;
        bit  forced;
        r      = int'(req);
        rel    = 1'b0;
        forced = 1'b0;
        m_tmo  = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (m_ptr + i) % NREQ;
                if (((r >> c) & 1) == 1) begin
                    m_owner = c;
                    m_hold  = 0;
                    break;
                end
            end
        end else begin
            if (done || ((r >> m_owner) & 1) == 0) begin
                rel = 1'b1;
            end
`ifdef REQ_SCHED_TIMEOUT_EN
            else if (m_hold + 1 == MAX_HOLD) begin
                rel    = 1'b1;
                forced = 1'b1;
            end
`endif
            else begin
                m_hold = m_hold + 1;
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_tmo   = forced;
            end
        end
    endfunction

    function automatic logic [31:0] exp_gnt();
        return (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_id();
        return (m_owner >= 0) ? 32'(m_owner) : 32'd0;
    endfunction

    // Advance the model on every rising edge and compare all outputs shortly after
    always @(posedge CLK) begin
        if (RST) model_reset();
        else     model_step(REQ, DONE);
        #1;
        checkOutput("model_gnt",     32'(GNT),     exp_gnt());
        checkOutput("model_gnt_id",  32'(GNT_ID),  exp_id());
        checkOutput("model_busy",    32'(BUSY),    32'(m_owner >= 0));
        checkOutput("model_timeout", 32'(TIMEOUT), 32'(m_tmo));
    end

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic done);
        @(negedge CLK);
        REQ  = req;
        DONE = done;
    endtask

    task automatic waitEdge();
        @(posedge CLK);
        #2;
    endtask

    task automatic doReset();
        @(negedge CLK);
        RST  = 1'b1;
        REQ  = '0;
        DONE = 1'b0;
        #1;
        checkOutput("rst_gnt",     32'(GNT),     32'd0);
        checkOutput("rst_gnt_id",  32'(GNT_ID),  32'd0);
        checkOutput("rst_busy",    32'(BUSY),    32'd0);
        checkOutput("rst_timeout", 32'(TIMEOUT), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Bound the whole run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired time=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        RST  = 1'b1;
        REQ  = '0;
        DONE = 1'b0;

        // Single requester: grant one cycle later, DONE releases
        doReset();
        applyStimulus(4'b0001, 1'b0);
        waitEdge();
        checkOutput("r028_gnt",    32'(GNT),    32'd1);
        checkOutput("r028_gnt_id", 32'(GNT_ID), 32'd0);
        checkOutput("r028_busy",   32'(BUSY),   32'd1);
        applyStimulus(4'b0001, 1'b1);
        waitEdge();
        checkOutput("r028_rel_gnt",  32'(GNT),  32'd0);
        checkOutput("r028_rel_busy", 32'(BUSY), 32'd0);
        applyStimulus(4'b0000, 1'b0);

        // All requesting with DONE held: 0,1,2,3,0 with dead cycles between
        doReset();
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 9; k++) begin
            waitEdge();
            checkOutput($sformatf("r029_gnt_%0d", k), 32'(GNT), 32'(seq029[k]));
        end
        applyStimulus(4'b0000, 1'b0);

        // Owner 2 drops its request, next grant goes to 3
        doReset();
        applyStimulus(4'b0100, 1'b0);
        waitEdge();
        checkOutput("r030_gnt_id", 32'(GNT_ID), 32'd2);
        applyStimulus(4'b1011, 1'b0);
        waitEdge();
        checkOutput("r030_dead_gnt", 32'(GNT), 32'd0);
        waitEdge();
        checkOutput("r030_next_gnt", 32'(GNT),    32'h8);
        checkOutput("r030_next_id",  32'(GNT_ID), 32'd3);
        applyStimulus(4'b0000, 1'b0);

        // Asynchronous reset while owner 1 holds the grant
        doReset();
        applyStimulus(4'b0010, 1'b0);
        waitEdge();
        checkOutput("r031_gnt_id", 32'(GNT_ID), 32'd1);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        checkOutput("r031_async_gnt",  32'(GNT),  32'd0);
        checkOutput("r031_async_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        REQ = 4'b0110;
        waitEdge();
        checkOutput("r031_regrant_gnt", 32'(GNT),    32'h2);
        checkOutput("r031_regrant_id",  32'(GNT_ID), 32'd1);
        applyStimulus(4'b0000, 1'b0);

`ifdef REQ_SCHED_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles, then DONE on the limit cycle
        doReset();
        applyStimulus(4'b0001, 1'b0);
        for (int k = 0; k < MAX_HOLD; k++) begin
            waitEdge();
            checkOutput($sformatf("r032_hold_%0d", k), 32'(GNT), 32'd1);
        end
        waitEdge();
        checkOutput("r032_tmo_gnt",   32'(GNT),     32'd0);
        checkOutput("r032_tmo_pulse", 32'(TIMEOUT), 32'd1);
        waitEdge();
        checkOutput("r032_regrant_gnt", 32'(GNT),     32'd1);
        checkOutput("r032_regrant_tmo", 32'(TIMEOUT), 32'd0);
        waitEdge();
        waitEdge();
        @(negedge CLK);
        DONE = 1'b1;
        waitEdge();
        checkOutput("r032_done_gnt", 32'(GNT),     32'd0);
        checkOutput("r032_done_tmo", 32'(TIMEOUT), 32'd0);
        applyStimulus(4'b0000, 1'b0);
`else
        // Without the timeout feature the grant is held indefinitely
        doReset();
        applyStimulus(4'b0001, 1'b0);
        held     = 0;
        tmo_seen = 0;
        repeat (100) begin
            waitEdge();
            if (GNT == 4'b0001) held++;
            if (TIMEOUT) tmo_seen++;
        end
        checkOutput("r033_held",     32'(held),     32'd100);
        checkOutput("r033_tmo_seen", 32'(tmo_seen), 32'd0);
        applyStimulus(4'b0000, 1'b0);
`endif

        // Randomized requests, DONE pulses and occasional mid-cycle resets
        for (int n = 0; n < 500; n++) begin
            @(negedge CLK);
            RST  = 1'b0;
            REQ  = 4'($urandom);
            DONE = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) begin
                #1 RST = 1'b1;
            end
        end
        @(negedge CLK);
        RST  = 1'b0;
        REQ  = '0;
        DONE = 1'b0;
        repeat (3) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
